euler_result_ascii: RTL

Downstream consumer of a Project Euler solver's `result` word. It captures the finished binary answer and converts it to decimal with a sequential double-dabble pass. It then streams the decimal digits as ASCII bytes, most significant digit first, over a valid/ready byte interface toward a UART or console sink. Leading zeros are suppressed.

---
 rtl/euler_pkg.sv | 30 +++
 rtl/bcd_adjust.sv | 15 +
 rtl/euler_result_ascii.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/euler_pkg.sv
// Shared types, constants and helpers for the Euler result-to-ASCII streamer.
// Optional feature macro: EULER_ASCII_NEWLINE_EN adds a trailing line-feed byte.
package euler_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

`ifdef EULER_ASCII_NEWLINE_EN
    typedef enum logic [2:0] {
        StIdle,
        StConvert,
        StLocate,
        StEmit,
        StNewline
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StConvert,
        StLocate,
        StEmit
    } state_e;
`endif

    // Decimal digits needed for a width-bit unsigned value: ceil(width * log10(2)).
    function automatic int unsigned digits_for(input int unsigned width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble nibble correction: add 3 to a BCD digit that is 5 or more.
module bcd_adjust (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    // Result never exceeds 12, so the 4-bit add cannot carry out.
    always_comb begin
        nib_o = nib_i;
        if (nib_i >= 4'd5) begin
            nib_o = nib_i + 4'd3;
        end
    end

endmodule

// File: rtl/euler_result_ascii.sv
// Captures a binary result, converts it to BCD with a bit-serial double-dabble pass and
// streams the decimal digits as ASCII (MSD first, leading zeros suppressed) over valid/ready.
// Optional feature macro: EULER_ASCII_NEWLINE_EN appends 0x0A and moves out_last onto it.
module euler_result_ascii
    import euler_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = digits_for(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] result,
    input  logic             result_valid,
    output logic             busy,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned PtrW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BcdW-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]   ptr_q, ptr_d, ptr_msd;
    logic [3:0]        cur_nib;
    logic              xfer;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adjust u_bcd_adjust (
            .nib_i (bcd_q[4*g +: 4]),
            .nib_o (bcd_adj[4*g +: 4])
        );
    end

    // Index of the most significant nonzero digit; 0 when the whole value is zero.
    always_comb begin
        ptr_msd = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                ptr_msd = PtrW'(i);
            end
        end
    end

    assign cur_nib = bcd_q[{ptr_q, 2'b00} +: 4];
    assign xfer    = out_valid && out_ready;

    // Outputs are decoded from registered state only, so out_valid never sees out_ready.
    always_comb begin
        busy      = (state_q != StIdle);
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 8'h00;
        case (state_q)
            StEmit: begin
                out_valid = 1'b1;
                out_data  = ASCII_ZERO + {4'h0, cur_nib};
`ifndef EULER_ASCII_NEWLINE_EN
                out_last  = (ptr_q == '0);
`endif
            end
`ifdef EULER_ASCII_NEWLINE_EN
            StNewline: begin
                out_valid = 1'b1;
                out_data  = ASCII_LF;
                out_last  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Next-state logic: capture, convert, locate MSD, then emit digits.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (result_valid) begin
                    shift_d = result;
                    bcd_d   = '0;
                    cnt_d   = CntW'(WIDTH);
                    state_d = StConvert;
                end
            end
            StConvert: begin
                {bcd_d, shift_d} = {bcd_adj[BcdW-2:0], shift_q, 1'b0};
                cnt_d            = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StLocate;
                end
            end
            StLocate: begin
                ptr_d   = ptr_msd;
                state_d = StEmit;
            end
            StEmit: begin
                if (xfer) begin
                    if (ptr_q != '0) begin
                        ptr_d = ptr_q - 1'b1;
                    end else begin
`ifdef EULER_ASCII_NEWLINE_EN
                        state_d = StNewline;
`else
                        state_d = StIdle;
`endif
                    end
                end
            end
`ifdef EULER_ASCII_NEWLINE_EN
            StNewline: begin
                if (xfer) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset drops any conversion or emission in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
